alu_arbiter: RTL and testbench

Shares one six-function 4-bit ALU datapath between two requesters (port 0, port 1) using a valid/ready handshake and round-robin arbitration. Each accepted request is latched, executed in a registered EXEC cycle, and returned on a single response channel tagged with the requester ID. The block sits between lab-level control logic and the ALU, replacing direct SW/KEY drive of the opcode and operands. A saturating completion counter and a sticky illegal-opcode flag are provided for debug on LEDR/HEX.

---
 rtl/alu_arbiter_pkg.sv | 49 ++++
 rtl/alu_arbiter_if.sv | 38 +++
 rtl/alu_arbiter_core.sv | 33 +++
 rtl/alu_arbiter.sv | 97 +++++++++
 tb/tb_alu_arbiter.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared opcodes, FSM encoding and adder helpers
// for the two-port ALU arbiter.
package alu_arbiter_pkg;

  localparam logic [2:0] OP_INC   = 3'd0;
  localparam logic [2:0] OP_RCA   = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_XOROR = 3'd3;
  localparam logic [2:0] OP_REDOR = 3'd4;
  localparam logic [2:0] OP_CAT   = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  function automatic logic [1:0] fa(
    input logic x,
    input logic y,
    input logic ci
  );
    return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

  function automatic logic [4:0] rca4(
    input logic [3:0] x,
    input logic [3:0] y,
    input logic       ci
  );
    logic [4:0] r;
    logic [1:0] s;
    logic c;
    r = '0;
    c = ci;
    for (int i = 0; i < 4; i++) begin
      s = fa(x[i], y[i], c);
      r[i] = s[0];
      c = s[1];
    end
    r[4] = c;
    return r;
  endfunction

  function automatic logic op_illegal(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two
// requesters, the consumer and the arbiter.
interface alu_arbiter_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [2:0] req0_op;
  logic [3:0] req0_a;
  logic [3:0] req0_b;
  logic       req1_valid;
  logic       req1_ready;
  logic [2:0] req1_op;
  logic [3:0] req1_a;
  logic [3:0] req1_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [7:0] rsp_data;
  logic [7:0] done_count;
  logic       op_err;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data,
    input  done_count, op_err
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data,
    output done_count, op_err
  );
endinterface

// File: rtl/alu_arbiter_core.sv
// Combinational six-function 4-bit ALU with
// an 8-bit result and illegal-opcode flag.
module alu_core
  import alu_arbiter_pkg::*;
(
  input  logic [2:0] op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] result,
  output logic       illegal
);
  logic [4:0] inc;
  logic [4:0] rca;
  logic [7:0] add;

  assign inc = rca4(a, 4'h0, 1'b1);
  assign rca = rca4(a, b, 1'b0);
  assign add = {4'h0, a} + {4'h0, b};

  always_comb begin
    result  = 8'h00;
    illegal = 1'b0;
    unique case (1'b1)
      (op == OP_INC):   result = {3'b000, inc};
      (op == OP_RCA):   result = {3'b000, rca};
      (op == OP_ADD):   result = add;
      (op == OP_XOROR): result = {a | b, a ^ b};
      (op == OP_REDOR): result = {7'd0, |{a, b}};
      (op == OP_CAT):   result = {a, b};
      default:          illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two
// requesters; accept, execute, then respond.
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input logic          clk,
  input logic          resetn,
  alu_arbiter_if.slave bus
);
  state_t     state, state_n;
  logic       last_grant;
  logic       grant0, grant1;
  logic       accept;
  logic       sel_id;
  logic [2:0] sel_op, op_q;
  logic [3:0] sel_a, sel_b;
  logic [3:0] a_q, b_q;
  logic       id_q;
  logic [7:0] res_q, cnt_q;
  logic       err_q;
  logic [7:0] alu_res;
  logic       alu_ill;

  // on a tie the port that did not win last time goes
  assign grant0 = bus.req0_valid &
                  (~bus.req1_valid | last_grant);
  assign grant1 = bus.req1_valid &
                  (~bus.req0_valid | ~last_grant);

  assign sel_id = grant1;
  assign sel_op = sel_id ? bus.req1_op : bus.req0_op;
  assign sel_a  = sel_id ? bus.req1_a  : bus.req0_a;
  assign sel_b  = sel_id ? bus.req1_b  : bus.req0_b;

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (grant0 | grant1) begin
          accept  = 1'b1;
          state_n = S_EXEC;
        end
      end
      S_EXEC: state_n = S_RESP;
      S_RESP: begin
        if (bus.rsp_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign bus.req0_ready = accept & grant0 & resetn;
  assign bus.req1_ready = accept & grant1 & resetn;
  assign bus.rsp_valid  = (state == S_RESP);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_data   = res_q;
  assign bus.done_count = cnt_q;
  assign bus.op_err     = err_q;

  alu_core u_core (
    .op      (op_q),
    .a       (a_q),
    .b       (b_q),
    .result  (alu_res),
    .illegal (alu_ill)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      op_q       <= 3'd0;
      a_q        <= 4'h0;
      b_q        <= 4'h0;
      id_q       <= 1'b0;
      res_q      <= 8'h00;
      cnt_q      <= 8'h00;
      err_q      <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        last_grant <= sel_id;
        id_q       <= sel_id;
        op_q       <= sel_op;
        a_q        <= sel_a;
        b_q        <= sel_b;
        if (op_illegal(sel_op)) err_q <= 1'b1;
      end
      if (state == S_EXEC)
        res_q <= alu_ill ? 8'h00 : alu_res;
      if (bus.rsp_valid && bus.rsp_ready &&
          cnt_q != 8'hFF)
        cnt_q <= cnt_q + 8'd1;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench: directed scenarios plus
// random traffic against a transaction-level model.
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic resetn;

  always #5 clk = ~clk;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // transaction-level model
  bit         busy;
  int         acc_cyc;
  bit         last;
  int         cyc;
  logic       exp_id;
  logic [7:0] exp_data;
  int         exp_done;
  bit         exp_err;
  int         rsp_cnt;
  int         g_q[$];
  logic [7:0] r_q[$];

  function automatic logic [7:0] ref_alu(
    input logic [2:0] op,
    input logic [3:0] a,
    input logic [3:0] b
  );
    int ia, ib;
    ia = int'(a);
    ib = int'(b);
    case (op)
      3'd0: return 8'(ia + 1);
      3'd1: return 8'(ia + ib);
      3'd2: return 8'(ia + ib);
      3'd3: return {a | b, a ^ b};
      3'd4: return ((ia + ib) != 0) ? 8'd1 : 8'd0;
      3'd5: return 8'(ia * 16 + ib);
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] rq(input int i);
    return (i < r_q.size()) ? r_q[i] : 8'hxx;
  endfunction

  function automatic int gq(input int i);
    return (i < g_q.size()) ? g_q[i] : -1;
  endfunction

  task automatic model_reset();
    busy     = 0;
    last     = 1;
    exp_done = 0;
    exp_err  = 0;
  endtask

  // one clock: check at negedge, advance model,
  // drop accepted valids just after the posedge
  task automatic cycle();
    bit e0, e1, ev, hs;
    @(negedge clk);
    e0 = !busy && bus.req0_valid &&
         (!bus.req1_valid || last);
    e1 = !busy && bus.req1_valid &&
         (!bus.req0_valid || !last);
    ev = busy && (cyc >= acc_cyc + 2);
    check("req0_ready", bus.req0_ready, e0);
    check("req1_ready", bus.req1_ready, e1);
    check("rsp_valid", bus.rsp_valid, ev);
    if (ev) begin
      check("rsp_id", bus.rsp_id, exp_id);
      check("rsp_data", bus.rsp_data, exp_data);
    end
    check("done_count", bus.done_count, exp_done);
    check("op_err", bus.op_err, exp_err);
    hs = ev && bus.rsp_ready;
    if (hs) begin
      r_q.push_back(bus.rsp_data);
      rsp_cnt++;
      busy = 0;
      if (exp_done < 255) exp_done++;
    end
    if (e0 || e1) begin
      busy    = 1;
      acc_cyc = cyc;
      last    = e1;
      exp_id  = e1;
      g_q.push_back(e1 ? 1 : 0);
      if (e1) begin
        exp_data = ref_alu(bus.req1_op, bus.req1_a,
                           bus.req1_b);
        if (bus.req1_op >= 3'd6) exp_err = 1;
      end else begin
        exp_data = ref_alu(bus.req0_op, bus.req0_a,
                           bus.req0_b);
        if (bus.req0_op >= 3'd6) exp_err = 1;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    if (e0) bus.req0_valid = 1'b0;
    if (e1) bus.req1_valid = 1'b0;
  endtask

  task automatic do_reset();
    resetn         = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    #1;
    check("rst_ready0", bus.req0_ready, 0);
    check("rst_ready1", bus.req1_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_id", bus.rsp_id, 0);
    check("rst_rsp_data", bus.rsp_data, 8'h00);
    check("rst_done", bus.done_count, 0);
    check("rst_op_err", bus.op_err, 0);
    model_reset();
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic send0(
    input logic [2:0] op,
    input logic [3:0] a,
    input logic [3:0] b
  );
    bus.req0_op    = op;
    bus.req0_a     = a;
    bus.req0_b     = b;
    bus.req0_valid = 1'b1;
  endtask

  task automatic send1(
    input logic [2:0] op,
    input logic [3:0] a,
    input logic [3:0] b
  );
    bus.req1_op    = op;
    bus.req1_a     = a;
    bus.req1_b     = b;
    bus.req1_valid = 1'b1;
  endtask

  task automatic drain();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (!busy && !bus.req0_valid &&
          !bus.req1_valid)
        break;
      cycle();
    end
    check("drain_bound", {busy, bus.req0_valid,
                          bus.req1_valid}, 0);
  endtask

  initial begin
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp_ready = 1'b0;
    cyc = 0;
    rsp_cnt = 0;
    do_reset();

    // single request, full-rate consumer
    r_q.delete();
    bus.rsp_ready = 1'b1;
    send0(3'd1, 4'h9, 4'h8);
    drain();
    check("t1_data", rq(0), 8'h11);
    check("t1_done", bus.done_count, 1);

    // contention: strict alternation
    do_reset();
    r_q.delete();
    g_q.delete();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 40 && g_q.size() < 4; i++) begin
      if (!bus.req0_valid) send0(3'd5, 4'h3, 4'hC);
      if (!bus.req1_valid) send1(3'd3, 4'h5, 4'h3);
      cycle();
    end
    check("t2_grants", g_q.size(), 4);
    check("t2_g0", gq(0), 0);
    check("t2_g1", gq(1), 1);
    check("t2_g2", gq(2), 0);
    check("t2_g3", gq(3), 1);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    drain();
    check("t2_r0", rq(0), 8'h3C);
    check("t2_r1", rq(1), 8'h76);

    // back-pressure holds the response
    r_q.delete();
    bus.rsp_ready = 1'b0;
    send1(3'd0, 4'hF, 4'h0);
    cycle();
    send0(3'd5, 4'h1, 4'h2);
    repeat (6) cycle();
    check("t3_held", bus.rsp_data, 8'h10);
    check("t3_none", r_q.size(), 0);
    drain();
    check("t3_r0", rq(0), 8'h10);
    check("t3_r1", rq(1), 8'h12);

    // OR-reduction boundary
    r_q.delete();
    send0(3'd4, 4'h0, 4'h0);
    drain();
    send0(3'd4, 4'h0, 4'h2);
    drain();
    check("t4_r0", rq(0), 8'h00);
    check("t4_r1", rq(1), 8'h01);

    // illegal opcode, sticky error
    r_q.delete();
    send0(3'd7, 4'hA, 4'h5);
    drain();
    send0(3'd2, 4'hF, 4'hF);
    drain();
    check("t5_r0", rq(0), 8'h00);
    check("t5_r1", rq(1), 8'h1E);
    check("t5_sticky", bus.op_err, 1);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      if (!bus.req0_valid && $urandom_range(0, 2) == 0)
        send0(3'($urandom_range(0, 7)),
              4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)));
      if (!bus.req1_valid && $urandom_range(0, 2) == 0)
        send1(3'($urandom_range(0, 7)),
              4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)));
      bus.rsp_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    drain();

    // reset while a request is executing
    send0(3'd1, 4'h3, 4'h4);
    cycle();
    check("t6_in_exec", busy, 1);
    r_q.delete();
    do_reset();
    bus.rsp_ready = 1'b1;
    repeat (6) cycle();
    check("t6_no_rsp", r_q.size(), 0);

    // saturation of the completion counter
    rsp_cnt = 0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 1200 && rsp_cnt < 300; i++) begin
      if (!bus.req0_valid)
        send0(3'($urandom_range(0, 5)),
              4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)));
      cycle();
    end
    bus.req0_valid = 1'b0;
    drain();
    check("t7_count", rsp_cnt >= 300, 1);
    check("t7_sat", bus.done_count, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
